fsm_vec_driver: RTL

// - Synthesizable stimulus source for the two-input detector FSMs (inputs x1/x2, output y).
// - Steps through a programmable table of {x1,x2} vectors, each held N cycles.
// - Can pulse the detector's reset mid-sequence, and samples y at the end of each step.
// - Compares y with an expected bit and reports mismatch and y-high counts.

---
 rtl/fsm_vec_driver_pkg.sv | 23 ++
 rtl/fsm_vec_driver_if.sv | 36 +++
 rtl/fsm_vec_driver_vec_table.sv | 24 ++
 rtl/fsm_vec_driver.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fsm_vec_driver_pkg.sv
// Shared definitions for the detector stimulus driver: FSM states and the
// bit layout of one vector-table entry.
package fsm_vec_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_t;

  // Entry layout: {hold, rpulse, chk, exp_y, x1, x2}
  localparam int X2_B     = 0;
  localparam int X1_B     = 1;
  localparam int EXP_B    = 2;
  localparam int CHK_B    = 3;
  localparam int RP_B     = 4;
  localparam int HOLD_LSB = 5;

  function automatic int entry_w(input int hold_w);
    return HOLD_LSB + hold_w;
  endfunction

endpackage

// File: rtl/fsm_vec_driver_if.sv
// Host/table-programming and detector-facing signals of the vector driver.
interface fsm_vec_driver_if
  import fsm_vec_driver_pkg::*;
#(
  parameter int AW     = 4,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
);
  localparam int ENTRY_W = entry_w(HOLD_W);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [AW:0]        len;
  logic               start;
  logic               busy;
  logic               done;
  logic               x1;
  logic               x2;
  logic               dut_rst;
  logic               y;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   y_ones;
  logic               fail;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, y,
    input  busy, done, x1, x2, dut_rst, err_cnt, y_ones, fail
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, y,
    output busy, done, x1, x2, dut_rst, err_cnt, y_ones, fail
  );

endinterface

// File: rtl/fsm_vec_driver_vec_table.sv
// Vector table: DEPTH x W register file, one synchronous write port and
// one asynchronous read port. Contents are not reset.
module fsm_vec_driver_vec_table #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_vec_driver.sv
// Stimulus source for two-input detector FSMs: plays a table of {x1,x2}
// vectors, optionally pulses the detector reset, and scores the sampled y.
module fsm_vec_driver
  import fsm_vec_driver_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  fsm_vec_driver_if.slave bus
);

  localparam int                ENTRY_W  = entry_w(HOLD_W);
  localparam logic [AW:0]       DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]       LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]     IDX_ONE  = AW'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t             state;
  logic [AW-1:0]      idx;
  logic [AW:0]        len_q;
  logic [AW:0]        len_c;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               cur_exp;
  logic               cur_chk;
  logic               cur_rp;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               tbl_we;
  logic               last_step;
  logic               y_hit;
  logic               mismatch;

  logic               busy_q;
  logic               done_q;
  logic               x1_q;
  logic               x2_q;
  logic               dut_rst_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   ones_q;
  logic               fail_q;

  assign tbl_we = bus.wr_en & ~busy_q;

  fsm_vec_driver_vec_table #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Read port looks one entry ahead while driving so the next step loads
  // on the same edge the current one ends, leaving no gap between steps.
  always_comb begin
    len_c   = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    rd_addr = (state == ST_DRIVE) ? idx + IDX_ONE : '0;
  end

  assign last_step = ({1'b0, idx} == len_q - LEN_ONE);
  assign y_hit     = bus.y & ~cur_rp;
  assign mismatch  = cur_chk & ~cur_rp & (bus.y != cur_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_q     <= '0;
      hold_cnt  <= '0;
      cur_exp   <= 1'b0;
      cur_chk   <= 1'b0;
      cur_rp    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x1_q      <= 1'b0;
      x2_q      <= 1'b0;
      dut_rst_q <= 1'b0;
      err_q     <= '0;
      ones_q    <= '0;
      fail_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (len_c != '0) begin
              state     <= ST_DRIVE;
              busy_q    <= 1'b1;
              len_q     <= len_c;
              idx       <= '0;
              err_q     <= '0;
              ones_q    <= '0;
              fail_q    <= 1'b0;
              hold_cnt  <= rd_data[ENTRY_W-1:HOLD_LSB];
              cur_exp   <= rd_data[EXP_B];
              cur_chk   <= rd_data[CHK_B];
              cur_rp    <= rd_data[RP_B];
              x1_q      <= rd_data[X1_B];
              x2_q      <= rd_data[X2_B];
              dut_rst_q <= rd_data[RP_B];
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end else begin
            if (y_hit && ones_q != '1) ones_q <= ones_q + CNT_ONE;
            if (mismatch) begin
              fail_q <= 1'b1;
              if (err_q != '1) err_q <= err_q + CNT_ONE;
            end
            if (last_step) begin
              state     <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              x1_q      <= 1'b0;
              x2_q      <= 1'b0;
              dut_rst_q <= 1'b0;
            end else begin
              idx       <= idx + IDX_ONE;
              hold_cnt  <= rd_data[ENTRY_W-1:HOLD_LSB];
              cur_exp   <= rd_data[EXP_B];
              cur_chk   <= rd_data[CHK_B];
              cur_rp    <= rd_data[RP_B];
              x1_q      <= rd_data[X1_B];
              x2_q      <= rd_data[X2_B];
              dut_rst_q <= rd_data[RP_B];
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.x1      = x1_q;
  assign bus.x2      = x2_q;
  assign bus.dut_rst = dut_rst_q;
  assign bus.err_cnt = err_q;
  assign bus.y_ones  = ones_q;
  assign bus.fail    = fail_q;

endmodule
